// File: rtl/det_sched_pkg.sv
// Shared types and defaults for the detector scheduler: FSM state encoding,
// default sizing and a one-hot helper used by the round-robin arbiter.
package det_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int N_REQ_DEF  = 4;
  localparam int WORD_W_DEF = 8;
  localparam int MAX_REQ    = 32;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [31:0] idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    v[idx[4:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req scanning ptr, ptr+1, ... mod N_REQ.
module rr_arbiter import det_sched_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0] pos;

  // Scan from lowest to highest priority so the last match wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(N_REQ)) pos = pos - SW'(N_REQ);
      if (req[pos[PTR_W-1:0]]) begin
        idx = pos[PTR_W-1:0];
        vld = 1'b1;
      end
    end
  end

  assign gnt = vld ? N_REQ'(onehot(32'(idx))) : '0;

endmodule

// File: rtl/detector_scheduler.sv
// Time-shares one serial sequence detector between N_REQ requesters: arbitrate,
// clear the detector, shift the latched word out MSB-first, report done + hit.
module detector_scheduler import det_sched_pkg::*; #(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    hit,
  output logic                    busy,
  output logic                    det_rst,
  output logic                    det_x,
  input  logic                    det_y
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  state_e                          state_q, state_d;
  logic [WORD_W-1:0]               shreg_q, shreg_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            hit_acc_q, hit_acc_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [PTR_W-1:0]                idx_q, idx_d;
  logic [N_REQ-1:0]                gnt_q, gnt_d;
  logic [N_REQ-1:0]                done_q, done_d;
  logic                            busy_q, busy_d;

  logic [N_REQ-1:0][WORD_W-1:0]    data_arr;
  logic [N_REQ-1:0]                arb_gnt;
  logic [PTR_W-1:0]                arb_idx;
  logic                            arb_vld;

  assign data_arr = data;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    hit_acc_d = hit_acc_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          shreg_d = data_arr[arb_idx];
          idx_d   = arb_idx;
          gnt_d   = arb_gnt;
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d     = '0;
        hit_acc_d = 1'b0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        // det_y lags det_x by one cycle, so the first shift cycle has no response yet.
        if (cnt_q != '0) hit_acc_d = hit_acc_q | det_y;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == PTR_LAST) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      hit_acc_q <= 1'b0;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      hit_acc_q <= hit_acc_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  // The response to the last bit only arrives during DONE, so it is folded in here.
  assign hit     = (|done_q) & (hit_acc_q | det_y);
  assign det_rst = RST | (state_q == CLR);
  assign det_x   = (state_q == SHIFT) & shreg_q[WORD_W-1];

endmodule

// File: tb/tb_detector_scheduler.sv
// Scoreboard bench for detector_scheduler paired with a model of the
// four-zeros serial detector (A..E, y=1 in E, registered).
module tb_detector_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt, done;
  logic           hit, busy, det_rst, det_x, det_y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dst    = 0;

  typedef struct {
    int idx;
    bit hit;
    int cyc;
  } exp_t;
  exp_t sb[$];

  detector_scheduler #(.N_REQ(N), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .data(data), .gnt(gnt), .done(done),
    .hit(hit), .busy(busy), .det_rst(det_rst), .det_x(det_x), .det_y(det_y)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Detector partner: x=0 advances A->E (saturating), x=1 returns to A.
  always @(posedge CLK) begin
    if (det_rst)     dst <= 0;
    else if (det_x)  dst <= 0;
    else if (dst < 4) dst <= dst + 1;
  end
  assign det_y = (dst == 4);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic push(input int idx, input bit h, input int c);
    exp_t e;
    e.idx = idx; e.hit = h; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic pulse_rst();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every done pulse.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      checks++;
      if (hit && done == '0) begin
        errors++;
        $display("FAIL hit_outside_done: hit=%0b done=%b", hit, done);
      end
      checks++;
      if ($countones(gnt) > 1) begin
        errors++;
        $display("FAIL gnt_onehot: gnt=%b", gnt);
      end
      if (done != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=%b at cycle %0d", done, cyc);
        end else begin
          exp_t e;
          logic [N-1:0] oh;
          e  = sb.pop_front();
          oh = 4'b0001 << e.idx;
          if (done !== oh) begin
            errors++;
            $display("FAIL done_vec: got %b expected %b", done, oh);
          end
          chk("gnt_in_done", 32'(gnt), 32'(oh));
          chk("hit", 32'(hit), 32'(e.hit));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] pat;
    RST  = 1'b1;
    req  = '0;
    data = {8'hF0, 8'h88, 8'hFF, 8'h0F};
    repeat (3) @(negedge CLK);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_det_x", 32'(det_x), 0);
    chk("rst_det_rst", 32'(det_rst), 1);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 1: requester 0, 0x0F -> hit; data changed after latch is ignored
    n = cyc; req = 4'b0001; push(0, 1'b1, n + 10);
    pat = 8'h0F;
    for (int k = 0; k < W; k++) begin
      wait_cyc(n + 2 + k);
      if (k == 1) data[7:0] = 8'hFF;
      chk("t1_det_x", 32'(det_x), 32'(pat[W-1-k]));
    end
    wait_cyc(n + 10); req = '0; data[7:0] = 8'h0F;
    wait_cyc(n + 14);

    // 2: requester 1, 0xFF -> no hit; det_rst for exactly one cycle
    n = cyc;
    chk("t2_det_rst_pre", 32'(det_rst), 0);
    req = 4'b0010; push(1, 1'b0, n + 10);
    wait_cyc(n + 1);
    chk("t2_det_rst_clr", 32'(det_rst), 1);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_gnt", 32'(gnt), 32'h2);
    wait_cyc(n + 2);
    chk("t2_det_rst_post", 32'(det_rst), 0);
    chk("t2_det_x_first", 32'(det_x), 1);
    wait_cyc(n + 10); req = '0;
    wait_cyc(n + 14);

    // 5: reset in 4th SHIFT cycle of requester 2, ptr was 2
    n = cyc; req = 4'b0100;
    wait_cyc(n + 5);
    RST = 1'b1; req = '0;
    #1;
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_det_rst", 32'(det_rst), 1);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    n = cyc; req = 4'b0101;
    push(0, 1'b1, n + 10); push(2, 1'b0, n + 21);
    wait_cyc(n + 10); req = 4'b0100;
    wait_cyc(n + 21); req = '0;
    wait_cyc(n + 25);

    // 3: all requesting -> 0,1,2,3,0 with period 11
    pulse_rst();
    n = cyc; req = 4'b1111;
    for (int k = 0; k < 5; k++) push(k % N, (k % N == 0 || k % N == 3), n + 10 + 11 * k);
    wait_cyc(n + 54); req = '0;
    wait_cyc(n + 58);
    chk("t3_idle_busy", 32'(busy), 0);

    // 4: requester 1 then 3, with req[3] rising mid-session
    pulse_rst();
    n = cyc; req = 4'b0010;
    push(1, 1'b0, n + 10); push(3, 1'b1, n + 21);
    wait_cyc(n + 4); req = 4'b1010;
    wait_cyc(n + 10); req = 4'b1000;
    wait_cyc(n + 21); req = '0;
    wait_cyc(n + 25);

    // 6: req[0] dropped in SHIFT cycle 3 -> session completes, no regrant
    n = cyc; req = 4'b0001; push(0, 1'b1, n + 10);
    wait_cyc(n + 4); req = '0;
    wait_cyc(n + 20);
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_busy", 32'(busy), 0);

    begin
      int t = 0;
      while (sb.size() != 0 && t < 200) begin @(negedge CLK); t++; end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d expected done pulses never seen", sb.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
